// File: rtl/reg_bus_writer.sv
// Producer side of the register-file write port: latches a command, holds it on
// the C bus for SETUP_CYCLES, then pulses the strobe(s) for the chosen destination.
module reg_bus_writer #(
   parameter int DATA_WIDTH   = 8,
   parameter int SETUP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_dest,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic [DATA_WIDTH-1:0] C_out,
   output logic                  write_a,
   output logic                  write_b,
   output logic                  write_o,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            write_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_DONE
   } state_t;

   localparam logic [2:0] SETUP_LOAD = 3'(SETUP_CYCLES - 1);
   localparam logic [1:0] TGT_OUT    = 2'b10;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] c_out_q;
   logic                  bcast_q;
   logic [1:0]            target_q;
   logic [1:0]            target_d;
   logic [2:0]            cnt_q;
   logic [2:0]            cnt_d;
   logic [2:0]            strobes_q;
   logic                  done_q;
   logic [7:0]            count_q;
   logic [7:0]            count_d;

   // Strobe vector is ordered {OUT, B, A}; target codes match cmd_dest.
   function automatic logic [2:0] onehot(input logic [1:0] t);
      case (t)
         2'b00:   return 3'b001;
         2'b01:   return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   always_comb begin
      target_d = target_q + 2'd1;
      cnt_d    = cnt_q - 3'd1;
      count_d  = count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         c_out_q   <= '0;
         bcast_q   <= 1'b0;
         target_q  <= 2'b00;
         cnt_q     <= 3'd0;
         strobes_q <= 3'b000;
         done_q    <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               strobes_q <= 3'b000;
               done_q    <= 1'b0;
               if (cmd_valid) begin
                  c_out_q  <= cmd_data;
                  bcast_q  <= (cmd_dest == 2'b11);
                  target_q <= (cmd_dest == 2'b11) ? 2'b00 : cmd_dest;
                  cnt_q    <= SETUP_LOAD;
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_q == 3'd0) begin
                  state_q   <= ST_STROBE;
                  strobes_q <= onehot(target_q);
                  count_q   <= count_d;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_STROBE: begin
               // Broadcast walks A -> B -> OUT on consecutive cycles.
               if (bcast_q && (target_q != TGT_OUT)) begin
                  target_q  <= target_d;
                  strobes_q <= onehot(target_d);
                  count_q   <= count_d;
               end else begin
                  strobes_q <= 3'b000;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign C_out       = c_out_q;
   assign write_a     = strobes_q[0];
   assign write_b     = strobes_q[1];
   assign write_o     = strobes_q[2];
   assign done        = done_q;
   assign write_count = count_q;

endmodule

// File: doc/reg_bus_writer.md
Name: reg_bus_writer

Overview:
- Producer side of the register-file write interface: it drives the shared C data bus and the one-hot write strobes write_a, write_b and write_o into the registers block.
- It accepts write commands over a valid/ready handshake and latches the data.
- It presents the data on C_out for a configurable setup time, then pulses the strobe(s) for the selected destination.
- Used by the control path to load the A, B and OUT registers.

Parameters:
- DATA_WIDTH, 8, width of cmd_data and C_out.
- SETUP_CYCLES, 1, cycles C_out is stable before the first strobe; legal range 1..7.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_dest  input  2  00=A, 01=B, 10=OUT, 11=broadcast (A, then B, then OUT).
- cmd_data  input  DATA_WIDTH  value to write.
- C_out  output  DATA_WIDTH  data bus; connects to the registers block's C_in.
- write_a  output  1  strobe for register A.
- write_b  output  1  strobe for register B.
- write_o  output  1  strobe for register OUT.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last strobe of a command.
- write_count  output  8  total strobes issued; wraps 255->0.

Behaviour:
- **Reset**
  - Synchronous, active-high: on a clk edge with rst=1, state=IDLE.
  - C_out=0, all strobes=0, done=0, busy=0, write_count=0; cmd_ready=1 from the next cycle.
  - rst dominates every other input.
- **Handshake**
  - A command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready = (state==IDLE), combinational from state only; it does not depend on cmd_valid.
  - cmd_dest and cmd_data are sampled only at acceptance; later input changes are ignored.
- **States**
  - IDLE:
    - cmd_ready=1 and all strobes are 0.
    - On accept: C_out<=cmd_data, dest latched, setup counter<=SETUP_CYCLES-1, go to SETUP.
  - SETUP:
    - C_out held and strobes 0.
    - If counter==0, go to STROBE; otherwise decrement.
  - STROBE:
    - Exactly one of write_a, write_b, write_o is high for this one cycle, per the current target.
    - write_count increments by 1.
    - For broadcast with target A or B, the target advances (A->B->OUT) and the state stays in STROBE; otherwise go to DONE.
  - DONE:
    - done=1 for one cycle, strobes 0, then go to IDLE.
- **Strobe and bus rules**
  - Strobes are registered outputs and never overlap.
  - C_out is constant from acceptance+1 through DONE.
  - C_out keeps its last value in IDLE until the next accepted command.
- **Latency** (accept at edge N, SETUP_CYCLES=S)
  - Strobe high in cycle N+S+1.
  - Single target: done in N+S+2, cmd_ready=1 in N+S+3.
  - Broadcast: strobes in N+S+1, N+S+2 and N+S+3; done in N+S+4.
- **Back-to-back**
  - A new command is accepted in the first IDLE cycle after DONE.
  - There is no overlap with the previous command.
  - Minimum single-target period is S+3 cycles.
- **Reset mid-operation**
  - Any in-flight command is dropped.
  - No further strobes are issued and done is not pulsed.
  - Outputs return to their reset values on the edge that samples rst=1.
- **cmd_valid while busy**
  - No effect.
  - The producer holds cmd_valid until cmd_ready.

Test Plan:
1. Reset, then cmd_dest=00 with cmd_data=8'h96 and S=1 (accept at edge N) -> C_out=8'h96 from N+1, write_a=1 only in cycle N+2, done in N+3, write_count=1, cmd_ready=1 in N+4.
2. Broadcast cmd_dest=11 with cmd_data=8'h5A -> write_a, write_b and write_o each high for one cycle on consecutive cycles, never two at once; C_out=8'h5A throughout; write_count increments by 3; one done pulse.
3. Change cmd_data to 8'hFF and cmd_valid during SETUP/STROBE after accepting 8'h3C to OUT -> C_out stays 8'h3C, only write_o pulses, the second value is accepted only after cmd_ready returns.
4. Assert rst in the SETUP cycle of a dest=01 command -> no write_b pulse and no done; C_out=0, write_count=0, cmd_ready=1 on the following cycle.
5. SETUP_CYCLES=3, dest=10 with 8'hC3 -> strobe exactly 4 cycles after acceptance; back-to-back commands are spaced by 6 cycles.
6. Issue 86 broadcasts (258 strobes) -> write_count wraps and reads 8'd2.
